// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream, instruction-memory write port and boot status of the loader
interface imem_loader_if #(parameter int ADDR_W = 8);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              error;
    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, error
    );
    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a checksummed byte-stream image into instruction memory and holds the core in reset until verified
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR} state_t;
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;
    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       sh_q, sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready;
    logic              xfer;
    logic [16:0]       hdr_count;
    assign ready          = state_q inside {HDR_HI, HDR_LO, DATA, CHK};
    assign xfer           = bus.byte_valid & ready;
    assign hdr_count      = {1'b0, count_q[15:8], bus.byte_data};
    assign bus.byte_ready = ready;
    assign bus.imem_we    = state_q == WRITE;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.busy       = state_q inside {HDR_HI, HDR_LO, DATA, WRITE, CHK};
    assign bus.done       = state_q == DONE;
    assign bus.error      = state_q == ERR;
    assign bus.core_rst   = state_q != DONE;
    // Next-state and datapath: header capture, word assembly with running XOR, one write cycle per word
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        csum_d  = csum_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_d = HDR_HI;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    csum_d  = '0;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = bus.byte_data;
                    state_d       = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    count_d[7:0] = bus.byte_data;
                    state_d      = hdr_count > MAX_WORDS ? ERR : hdr_count == 17'd0 ? CHK : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    sh_d   = {sh_q[15:0], bus.byte_data};
                    csum_d = csum_q ^ bus.byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = WRITE;
                        addr_d  = idx_q[ADDR_W-1:0];
                        wdata_d = {sh_q, bus.byte_data};
                    end
                end
            end
            WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_q + 16'd1 == count_q) ? CHK : DATA;
            end
            CHK: begin
                if (xfer) state_d = bus.byte_data == csum_q ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and datapath registers; reset returns to IDLE with a cleared write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            csum_q  <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            csum_q  <= csum_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for the instruction-memory loader
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int wcount = 0;
    bit gap_chk = 1'b0;
    longint last_we_t = 0;
    logic [39:0] sb[$];
    imem_loader_if #(.ADDR_W(8)) bus();
    imem_loader #(.ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Write monitor: every imem_we pulse is matched against the scoreboard
    always @(negedge clk) begin : mon
        logic [39:0] e;
        if (bus.imem_we) begin
            wcount++;
            check("we_ready_low", bus.byte_ready, 0);
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("waddr", bus.imem_addr, e[39:32]);
                check("wdata", bus.imem_wdata, e[31:0]);
            end
            if (gap_chk && last_we_t != 0) check("we_gap", $time - last_we_t, 50);
            last_we_t = $time;
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic send(input logic [7:0] b, input bit stall);
        int n = 0;
        if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_ready_wait", bus.byte_ready, 1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_ready", bus.byte_ready, 1);
        check("start_busy", bus.busy, 1);
        check("start_core_rst", bus.core_rst, 1);
        check("start_done_clr", bus.done, 0);
        check("start_err_clr", bus.error, 0);
    endtask
    task automatic load(input logic [31:0] w[$], input bit stall, input bit bad);
        logic [7:0] cs = 8'h00;
        logic [15:0] n = 16'(w.size());
        int wc0 = wcount;
        pulse_start();
        last_we_t = 0;
        gap_chk = !stall;
        send(n[15:8], stall);
        send(n[7:0], stall);
        foreach (w[i]) begin
            sb.push_back({8'(i), w[i]});
            for (int b = 3; b >= 0; b--) begin
                send(w[i][8*b +: 8], stall);
                cs ^= w[i][8*b +: 8];
            end
        end
        send(bad ? 8'h00 : cs, stall);
        gap_chk = 1'b0;
        check("load_done", bus.done, !bad);
        check("load_error", bus.error, bad);
        check("load_core_rst", bus.core_rst, bad);
        check("load_busy", bus.busy, 0);
        check("load_wcount", wcount - wc0, n);
        check("load_sb_empty", sb.size(), 0);
    endtask
    initial begin
        logic [31:0] w2[$];
        logic [31:0] w4[$];
        logic [31:0] wbig[$];
        int wc0;
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        @(negedge clk);
        check("rst_ready", bus.byte_ready, 0);
        check("rst_we", bus.imem_we, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_core_rst", bus.core_rst, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        rst = 1'b0;
        @(negedge clk);
        w2 = '{32'h3C010005, 32'h00210820};
        load(w2, 0, 0);
        check("hold_addr", bus.imem_addr, 1);
        check("hold_wdata", bus.imem_wdata, 32'h00210820);
        check("hold_we", bus.imem_we, 0);
        load(w2, 0, 1);
        wc0 = wcount;
        pulse_start();
        send(8'h01, 0);
        send(8'h01, 0);
        check("oversize_error", bus.error, 1);
        check("oversize_core_rst", bus.core_rst, 1);
        check("oversize_ready", bus.byte_ready, 0);
        check("oversize_no_we", wcount - wc0, 0);
        wc0 = wcount;
        pulse_start();
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        check("zero_done", bus.done, 1);
        check("zero_core_rst", bus.core_rst, 0);
        check("zero_no_we", wcount - wc0, 0);
        for (int i = 0; i < 4; i++) w4.push_back($urandom);
        load(w4, 0, 0);
        load(w4, 1, 0);
        for (int i = 0; i < 256; i++) wbig.push_back($urandom);
        load(wbig, 0, 0);
        check("full_last_addr", bus.imem_addr, 8'hFF);
        check("full_last_wdata", bus.imem_wdata, wbig[255]);
        wc0 = wcount;
        pulse_start();
        sb.push_back({8'h00, 32'h12345678});
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_start_busy", bus.busy, 1);
        check("mid_start_ready", bus.byte_ready, 1);
        send(8'h56, 0);
        send(8'h78, 0);
        send(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78, 0);
        check("reload_done", bus.done, 1);
        check("reload_wcount", wcount - wc0, 1);
        pulse_start();
        sb.push_back({8'h00, 32'hAABBCCDD});
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'hCC, 0);
        send(8'hDD, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", bus.byte_ready, 0);
        check("arst_we", bus.imem_we, 0);
        check("arst_addr", bus.imem_addr, 0);
        check("arst_wdata", bus.imem_wdata, 0);
        check("arst_core_rst", bus.core_rst, 1);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_error", bus.error, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_ready", bus.byte_ready, 0);
        check("idle_busy", bus.busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
